// File: rtl/pe_spad_mac_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | pe_spad_mac_pipe : 2-stage signed MAC / psum PE with scratchpad and drain  |
// | Optional macro SATURATE_EN: saturating stage-2 adds instead of wrapping.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pe_spad_mac_pipe #(
  parameter int DATA_W     = 16,
  parameter int PSUM_W     = 32,
  parameter int SPAD_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [1:0]                    mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             filter_data,
  input  logic [DATA_W-1:0]             ifmap_data,
  input  logic [PSUM_W-1:0]             input_psum,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PSUM_W-1:0]             psum_out,
  output logic [$clog2(SPAD_DEPTH)-1:0] out_addr,
  output logic                          busy
);

  localparam int PTR_W = $clog2(SPAD_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [1:0] M_ACC   = 2'd0;
  localparam logic [1:0] M_INIT  = 2'd1;
  localparam logic [1:0] M_PSUM  = 2'd2;
  localparam logic [1:0] M_DRAIN = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [PTR_W-1:0]         ptr_q;
  logic                     s1_valid_q, s1_init_q, s2_valid_q;
  logic [PTR_W-1:0]         s1_ptr_q;
  logic signed [PSUM_W-1:0] s1_opnd_q, opnd_d;
  logic signed [PSUM_W-1:0] spad_q [SPAD_DEPTH];
  logic                     out_valid_q;
  logic [PSUM_W-1:0]        psum_out_q;
  logic [PTR_W-1:0]         out_addr_q;

  logic                     w_accept, w_load, w_drain_req, w_out_hs, w_last;
  logic                     w_pipe_empty, w_drain_start;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [PSUM_W-1:0] w_old, w_wr_data;

  assign in_ready      = (state_q != ST_DRAIN);
  assign w_accept      = in_valid & in_ready;
  assign w_load        = w_accept & (mode != M_DRAIN);
  assign w_drain_req   = w_accept & (mode == M_DRAIN);
  assign w_out_hs      = out_valid_q & out_ready;
  assign w_last        = (out_addr_q == PTR_W'(SPAD_DEPTH - 1));
  assign w_pipe_empty  = ~s1_valid_q & ~s2_valid_q;
  assign w_drain_start = (state_q == ST_FLUSH) & (state_d == ST_DRAIN);

  assign w_prod = $signed({{DATA_W{filter_data[DATA_W-1]}}, filter_data}) *
                  $signed({{DATA_W{ifmap_data[DATA_W-1]}}, ifmap_data});
  assign opnd_d = (mode == M_PSUM) ? $signed(input_psum) : PSUM_W'(w_prod);
  assign w_old  = spad_q[s1_ptr_q];

`ifdef SATURATE_EN
  logic [PSUM_W:0]   w_sum_wide;
  logic              w_ovf;
  logic              sat_q;
  logic [PSUM_W-1:0] w_sat_val;

  assign w_sum_wide = {w_old[PSUM_W-1], w_old} + {s1_opnd_q[PSUM_W-1], s1_opnd_q};
  assign w_ovf      = w_sum_wide[PSUM_W] ^ w_sum_wide[PSUM_W-1];
  assign w_sat_val  = w_sum_wide[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}}
                                         : {1'b0, {(PSUM_W-1){1'b1}}};
  assign w_wr_data  = s1_init_q ? s1_opnd_q :
                      (w_ovf ? $signed(w_sat_val) : $signed(w_sum_wide[PSUM_W-1:0]));

  // Sticky overflow indication, cleared once a full drain completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_q <= 1'b0;
    end else if (w_out_hs && w_last) begin
      sat_q <= 1'b0;
    end else if (s1_valid_q && !s1_init_q && w_ovf) begin
      sat_q <= 1'b1;
    end
  end
`else
  assign w_wr_data = s1_init_q ? s1_opnd_q : (w_old + s1_opnd_q);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_drain_req)  state_d = ST_FLUSH;
        else if (w_load)  state_d = ST_RUN;
      end
      ST_RUN: begin
        if (w_drain_req)                       state_d = ST_FLUSH;
        else if (!w_accept && w_pipe_empty)    state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        if (w_pipe_empty && !w_load)           state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_out_hs && w_last)                state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_init_q  <= 1'b0;
      s1_ptr_q   <= '0;
      s1_opnd_q  <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= w_load;
      s2_valid_q <= s1_valid_q;
      if (w_load) begin
        s1_init_q <= (mode == M_INIT);
        s1_ptr_q  <= ptr_q;
        s1_opnd_q <= opnd_d;
        ptr_q     <= ptr_q + PTR_W'(1);
      end else if (w_out_hs && w_last) begin
        ptr_q     <= '0;
      end
    end
  end

  // Stage-2 writes and drain clears never coincide: drain only runs with the pipe empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SPAD_DEPTH; i++) spad_q[i] <= '0;
    end else begin
      if (s1_valid_q) spad_q[s1_ptr_q] <= w_wr_data;
      if (w_out_hs)   spad_q[out_addr_q] <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      psum_out_q  <= '0;
    end else if (w_drain_start) begin
      out_valid_q <= 1'b1;
      out_addr_q  <= '0;
      psum_out_q  <= spad_q[0];
    end else if (w_out_hs) begin
      if (w_last) begin
        out_valid_q <= 1'b0;
      end else begin
        out_addr_q  <= out_addr_q + PTR_W'(1);
        psum_out_q  <= spad_q[out_addr_q + PTR_W'(1)];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign psum_out  = psum_out_q;
  assign out_addr  = out_addr_q;
  assign busy      = s1_valid_q | s2_valid_q | (state_q == ST_FLUSH) | (state_q == ST_DRAIN);

endmodule
`default_nettype wire

// File: doc/pe_spad_mac_pipe.md
Name: pe_spad_mac_pipe

Overview:
- Parametrised next-generation Eyeriss processing element: signed MAC and psum accumulation into a multi-entry psum scratchpad.
- Adds valid/ready handshakes on both sides, a 2-stage pipeline and a drain mode.
- Sits in the PE array between the ifmap/filter NoC (input side) and the psum collection NoC (output side).

Parameters:
- DATA_W, 16, width of signed filter_data / ifmap_data.
- PSUM_W, 32, width of signed psum entries; must be >= 2*DATA_W.
- SPAD_DEPTH, 16, number of scratchpad entries; power of two, >= 2. Internal pointer width is log2(SPAD_DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mode  in  2  00 MAC_ACC, 01 MAC_INIT, 10 PSUM_ACC, 11 DRAIN; sampled only on an input handshake.
- in_valid  in  1  input beat valid.
- in_ready  out  1  PE can accept a beat.
- filter_data  in  DATA_W  signed weight.
- ifmap_data  in  DATA_W  signed activation.
- input_psum  in  PSUM_W  signed psum for PSUM_ACC.
- out_valid  out  1  drained entry valid.
- out_ready  in  1  downstream accepts the entry.
- psum_out  out  PSUM_W  drained entry value.
- out_addr  out  log2(SPAD_DEPTH)  index of the drained entry.
- busy  out  1  high while the pipeline is non-empty or in DRAIN.

Behaviour:
- Reset (async, reset_n=0):
  - All scratchpad entries, pointer, pipeline valids, psum_out and out_addr go to 0.
  - out_valid=0, busy=0, state=IDLE.
  - in_ready=1 from the first cycle after release.
  - Reset mid-drain or mid-pipeline discards everything.
- Handshake: a beat is accepted when in_valid & in_ready at a clk edge. in_ready = (state != DRAIN).
- Stage 1, on accept with mode 00/01/10:
  - Registers mode and pointer.
  - Registers operand = sign-extended filter_data*ifmap_data (00/01) or input_psum (10).
  - Pointer increments, wrapping SPAD_DEPTH-1 -> 0.
- Stage 2, the cycle after stage 1: single-cycle read-modify-write.
  - MAC_ACC and PSUM_ACC: spad[p] = spad[p] + operand.
  - MAC_INIT: spad[p] = operand.
  - Update latency: the entry reflects the beat 2 edges after accept.
  - No hazard exists because stage 2 completes within its cycle.
- Back-to-back beats are accepted every cycle, including mode changes between beats; the pointer is shared across modes.
- Arithmetic: adds are two's complement, modulo 2^PSUM_W (wrap) unless SATURATE_EN is defined.
- State machine: IDLE -> RUN -> FLUSH -> DRAIN -> IDLE.
  - IDLE -> RUN on the first accepted non-DRAIN beat.
  - RUN -> IDLE when the pipeline is empty and no beat is accepted.
  - Accepted DRAIN beat (from IDLE or RUN) -> FLUSH. The beat carries no data.
  - FLUSH waits for stage 2 to empty (at most 2 cycles), then -> DRAIN with drain index 0.
  - DRAIN presents spad[k] on psum_out with out_addr=k and out_valid=1. psum_out and out_addr stay stable while out_ready=0.
  - On each out handshake: spad[k] is cleared to 0, k increments.
  - After index SPAD_DEPTH-1 is handed off: out_valid=0, pointer=0, state -> IDLE, in_ready=1 in the next cycle.
- busy = stage1 valid | stage2 valid | state in {FLUSH, DRAIN}.
- Outputs are registered; there is no combinational path from in_valid to out_valid.

Optional Feature:
- Macro SATURATE_EN.
- Defined: every stage-2 add saturates to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1], and a sticky internal sat flag is cleared by the drain.
- Undefined: adds wrap modulo 2^PSUM_W; no saturation logic is generated.

Test Plan:
- Reset release, then 4 MAC_INIT beats (f=3, i=-2) followed by one DRAIN beat, out_ready=1 -> entries 0..3 drain as -6, entries 4..15 as 0; out_addr 0..15 in order; then idle with in_ready=1.
- MAC_ACC, 32 beats of f=1, i=5 (pointer wraps once), then drain -> every entry = 10; pointer back at 0 afterwards.
- PSUM_ACC with input_psum=100 on entries 0..15, then MAC_ACC f=2, i=3 on 0..15, then drain -> every entry 106; back-to-back beats with in_ready held at 1 throughout.
- DRAIN with out_ready toggling 1/0 every cycle -> psum_out and out_addr stable during stalls; exactly 16 handshakes; in_ready=0 throughout; drained entries read 0 on the next drain.
- Sum overflow: PSUM_W=32, PSUM_ACC with 0x7FFFFFFF then 1 on the same entry -> 0x80000000 without SATURATE_EN, 0x7FFFFFFF with it.
- reset_n asserted after 5 of 16 drain handshakes -> out_valid=0 immediately; the subsequent full drain returns all zeros.
